unidad_ejecucion: RTL
=====================

Name: unidad_ejecucion

Overview:
Multi-cycle execute stage that sits directly downstream of the register bank and feeds results back into it.
- Consumes the bank's RX/RY read outputs and performs ALU, multiply or divide operations.
- Drives the bank's write port (Dat, R_W, E_N) with registered results.
- Start/Busy handshake toward the control unit. Single-cycle ops take 1 write-back cycle; MUL/DIV take an 8-cycle iterative core plus 2 write-back cycles.

Parameters:
ANCHO, 8, data width of operands and results
NBITS_REG, 3, register address width (8 registers, R0..R7)

Ports:
Clk    in   1          rising-edge clock
Rst    in   1          asynchronous reset, active-low
Start  in   1          launch request, sampled only while Busy=0
Op     in   3          000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV(RY), 110 MUL, 111 DIV
RX     in   ANCHO      operand A, from register bank
RY     in   ANCHO      operand B, from register bank
Dst    in   NBITS_REG  destination register
Dat    out  ANCHO      write data to register bank
R_W    out  NBITS_REG  write address to register bank
E_N    out  1          write enable to register bank, 1-cycle pulses
Busy   out  1          operation in progress
Z      out  1          zero flag
C      out  1          carry / borrow / overflow / divide-by-zero flag

Behaviour:
- Clock and reset: one clock Clk; Rst is asynchronous, active-low.
- Reset (Rst=0, any state, including mid-MUL/DIV): state=IDLE, Dat=0, R_W=0, E_N=0, Busy=0, Z=0, C=0, iteration counter=0. The in-flight op is discarded and no write occurs.
- All outputs are registered. The register bank captures Dat/R_W at the edge where it sees E_N=1.
- States: IDLE, ITER, WB_LO, WB_HI.
- IDLE:
  - On an edge with Start=1, latch Op, RX, RY, Dst and set Busy=1.
  - Op 000-101 -> WB_LO.
  - MUL -> ITER with counter=0.
  - DIV with RY!=0 -> ITER.
  - DIV with RY=0 -> WB_LO directly, divide-by-zero path.
- Start while Busy=1 is ignored, with no queuing.
- Op arithmetic:
  - ADD: 9-bit sum; Dat=sum[7:0]; C=sum[8].
  - SUB: Dat=RX-RY mod 256; C=1 iff RX<RY (borrow).
  - AND, OR, XOR, MOV: C unchanged.
- ITER, exactly 8 cycles, counter 0..7:
  - MUL: shift-add, unsigned 16-bit product.
  - DIV: restoring division, unsigned; quotient and remainder 8 bits each.
  - After counter=7 -> WB_LO.
- WB_LO, 1 cycle, E_N=1, R_W=Dst:
  - Dat = result, product[7:0], or quotient.
  - Z=(Dat==0).
  - C update: MUL sets C=(product[15:8]!=0); DIV sets C=divide-by-zero.
  - Single-cycle ops -> IDLE, Busy=0 next cycle. MUL/DIV -> WB_HI.
- WB_HI, 1 cycle, E_N=1:
  - R_W=(Dst+1) mod 8, so R7 wraps to R0.
  - Dat = product[15:8] or remainder.
  - Then -> IDLE. Z and C are not changed.
- Divide by zero: quotient=8'hFF, remainder=RX, C=1. No ITER cycles; Busy is high for 2 cycles.
- Latency from the Start edge, counting E_N pulses:
  - Single-cycle op: E_N high on cycle +1; Busy high 1 cycle.
  - MUL/DIV: E_N high on cycles +9 and +10; Busy high 10 cycles.
- E_N is 0 in every state other than WB_LO and WB_HI. Dat and R_W hold their last value when E_N=0.
- Z and C hold between operations.
- Operands are latched at Start, so RX/RY may change freely while Busy=1 (including from its own write-back).

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD..OP_DIV
  - state encodings IDLE/ITER/WB_LO/WB_HI
  - ANCHO/NBITS_REG defaults
- One sub-module: iterador_muldiv. It holds the 8-step shift-add / restoring-divide datapath and counter, with inputs load/es_div/a/b and outputs listo/alto/bajo. The parent FSM handles the handshake, single-cycle ALU, flags and write-back sequencing.

Test Plan:
- ADD RX=200, RY=100, Dst=R1 -> one E_N pulse at +1, R_W=1, Dat=0x2C, C=1, Z=0; Busy high 1 cycle.
- SUB RX=5, RY=5, Dst=R2 -> Dat=0x00, Z=1, C=0; then SUB RX=3, RY=4 -> Dat=0xFF, C=1, Z=0.
- MUL RX=13, RY=20, Dst=R2 -> E_N at +9 (R_W=2, Dat=0x04) and +10 (R_W=3, Dat=0x01); C=1, Z=0; Busy high exactly 10 cycles; Start pulses at +3 and +5 ignored.
- DIV RX=100, RY=7, Dst=R7 -> R7=0x0E, then R0=0x02 (wrap); C=0. DIV RX=9, RY=0, Dst=R4 -> E_N at +1 (R4=0xFF) and +2 (R5=0x09); C=1.
- Reset mid-op: launch MUL, drive Rst=0 at +4 -> E_N=0, Busy=0, Z=C=0 immediately; no write after release; a new ADD 1+1 then gives Dat=0x02.
- Back-to-back: Start held high continuously with ops ADD, MOV -> ops accepted on alternating cycles only (each accepted when Busy=0); E_N pulses carry the correct Dat and R_W per op.

Source files
------------

// File: rtl/unidad_ejecucion_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM states, default widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package unidad_ejecucion_pkg;

    localparam int ANCHO_DEF     = 8;
    localparam int NBITS_REG_DEF = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } estado_t;

    // MUL and DIV write back two registers (low/high or quotient/remainder).
    function automatic logic es_doble(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/unidad_ejecucion_iterador_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Latency: ANCHO cycles after load; listo flags the final step, alto/bajo carry that step's result.
// Backpressure: none; a new load restarts the core, the parent only loads when idle.
// Ports: Clk/Rst clock and async active-low reset; load/es_div/a/b start an operation;
//        listo final-step strobe; alto = product high / remainder, bajo = product low / quotient.
module iterador_muldiv #(
    parameter int ANCHO = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load,
    input  logic             es_div,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    output logic             listo,
    output logic [ANCHO-1:0] alto,
    output logic [ANCHO-1:0] bajo
);
    localparam int CW = $clog2(ANCHO);
    localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);

    logic [ANCHO-1:0] hi_q, lo_q, b_q;
    logic [ANCHO-1:0] hi_d, lo_d;
    logic [CW-1:0]    cnt_q;
    logic             div_q, act_q;
    logic [ANCHO:0]   suma, desp, resta;

    always_comb begin
        suma  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // Partial remainder shifted left with the next dividend bit; it stays
        // below 2*b, so the MSB of the trial subtraction is the borrow.
        desp  = {hi_q, lo_q[ANCHO-1]};
        resta = desp - {1'b0, b_q};
        if (div_q) begin
            if (!resta[ANCHO]) begin
                hi_d = resta[ANCHO-1:0];
                lo_d = {lo_q[ANCHO-2:0], 1'b1};
            end else begin
                hi_d = desp[ANCHO-1:0];
                lo_d = {lo_q[ANCHO-2:0], 1'b0};
            end
        end else begin
            // Add-then-shift-right on {carry, hi, lo}; multiplier drains out of lo.
            hi_d = suma[ANCHO:1];
            lo_d = {suma[0], lo_q[ANCHO-1:1]};
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
            act_q <= 1'b0;
        end else if (load) begin
            hi_q  <= '0;
            lo_q  <= a;
            b_q   <= b;
            cnt_q <= '0;
            div_q <= es_div;
            act_q <= 1'b1;
        end else if (act_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == ULTIMO) begin
                act_q <= 1'b0;
            end
        end
    end

    assign listo = act_q && (cnt_q == ULTIMO);
    assign alto  = hi_d;
    assign bajo  = lo_d;

endmodule

// File: rtl/unidad_ejecucion.sv
// Execute stage: single-cycle ALU plus iterative MUL/DIV, writing results back to the register bank.
// Latency: ALU ops write on cycle +1; MUL/DIV write on cycles +9/+10 (div-by-zero on +1/+2).
// Backpressure: Busy high while an op is in flight; Start is ignored (not queued) while Busy=1.
// Ports: Clk, Rst (async active-low); Start/Op/RX/RY/Dst launch an op; Dat/R_W/E_N drive the
//        bank write port; Busy handshake; Z/C flags held between operations.
module unidad_ejecucion
    import unidad_ejecucion_pkg::*;
#(
    parameter int ANCHO     = ANCHO_DEF,
    parameter int NBITS_REG = NBITS_REG_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [2:0]           Op,
    input  logic [ANCHO-1:0]     RX,
    input  logic [ANCHO-1:0]     RY,
    input  logic [NBITS_REG-1:0] Dst,
    output logic [ANCHO-1:0]     Dat,
    output logic [NBITS_REG-1:0] R_W,
    output logic                 E_N,
    output logic                 Busy,
    output logic                 Z,
    output logic                 C
);
    estado_t              estado_q;
    logic [2:0]           op_q;
    logic [NBITS_REG-1:0] dst_q, rw_q;
    logic [ANCHO-1:0]     alto_q, dat_q;
    logic                 en_q, busy_q, z_q, c_q;

    logic [ANCHO:0]       suma_alu, resta_alu;
    logic [ANCHO-1:0]     res_alu, it_alto, it_bajo;
    logic                 c_alu, cargar, it_listo;

    // Immediate result for everything that writes back on cycle +1,
    // including the divide-by-zero case (quotient all ones, C set).
    always_comb begin
        suma_alu  = {1'b0, RX} + {1'b0, RY};
        resta_alu = {1'b0, RX} - {1'b0, RY};
        res_alu   = RY;
        c_alu     = c_q;
        case (Op)
            OP_ADD: begin res_alu = suma_alu[ANCHO-1:0];  c_alu = suma_alu[ANCHO];  end
            OP_SUB: begin res_alu = resta_alu[ANCHO-1:0]; c_alu = resta_alu[ANCHO]; end
            OP_AND: res_alu = RX & RY;
            OP_OR:  res_alu = RX | RY;
            OP_XOR: res_alu = RX ^ RY;
            OP_DIV: begin res_alu = '1; c_alu = 1'b1; end
            default: res_alu = RY;
        endcase
    end

    assign cargar = (estado_q == IDLE) && Start &&
                    ((Op == OP_MUL) || ((Op == OP_DIV) && (RY != '0)));

    iterador_muldiv #(.ANCHO(ANCHO)) u_iter (
        .Clk    (Clk),
        .Rst    (Rst),
        .load   (cargar),
        .es_div (Op == OP_DIV),
        .a      (RX),
        .b      (RY),
        .listo  (it_listo),
        .alto   (it_alto),
        .bajo   (it_bajo)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            estado_q <= IDLE;
            op_q     <= '0;
            dst_q    <= '0;
            alto_q   <= '0;
            dat_q    <= '0;
            rw_q     <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            en_q <= 1'b0;
            case (estado_q)
                IDLE: begin
                    if (Start) begin
                        busy_q <= 1'b1;
                        op_q   <= Op;
                        dst_q  <= Dst;
                        if (cargar) begin
                            estado_q <= ITER;
                        end else begin
                            // Outputs are loaded now so the write lands on cycle +1.
                            // alto_q keeps RX as the div-by-zero remainder.
                            estado_q <= WB_LO;
                            dat_q    <= res_alu;
                            rw_q     <= Dst;
                            en_q     <= 1'b1;
                            z_q      <= (res_alu == '0);
                            c_q      <= c_alu;
                            alto_q   <= RX;
                        end
                    end
                end
                ITER: begin
                    if (it_listo) begin
                        estado_q <= WB_LO;
                        dat_q    <= it_bajo;
                        rw_q     <= dst_q;
                        en_q     <= 1'b1;
                        z_q      <= (it_bajo == '0);
                        c_q      <= (op_q == OP_MUL) ? (it_alto != '0) : 1'b0;
                        alto_q   <= it_alto;
                    end
                end
                WB_LO: begin
                    if (es_doble(op_q)) begin
                        estado_q <= WB_HI;
                        dat_q    <= alto_q;
                        rw_q     <= dst_q + NBITS_REG'(1);
                        en_q     <= 1'b1;
                    end else begin
                        estado_q <= IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                WB_HI: begin
                    estado_q <= IDLE;
                    busy_q   <= 1'b0;
                end
                default: begin
                    estado_q <= IDLE;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign Dat  = dat_q;
    assign R_W  = rw_q;
    assign E_N  = en_q;
    assign Busy = busy_q;
    assign Z    = z_q;
    assign C    = c_q;

endmodule
